// File: rtl/spu_local_store_pipe.sv
// SPU local store pipeline for the odd pipe: quadword lq/stq in x-, d- and a-form with a fixed-latency writeback shift pipe.
// Optional macro LS_CLEAR_ON_RESET_EN adds a post-reset clear engine that zeroes every line before ready rises.
module spu_local_store_pipe #(
    parameter int LS_BYTES = 32768,
    parameter int LATENCY  = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [1:0]   ls_op,
    input  logic [1:0]   addr_mode,
    input  logic [6:0]   rt_addr,
    input  logic [127:0] ra,
    input  logic [127:0] rb,
    input  logic [127:0] rt_st,
    input  logic [15:0]  imm,
    output logic         ready,
    output logic [127:0] rt_wb,
    output logic [6:0]   rt_addr_wb,
    output logic         reg_write_wb
);

    localparam int LINES  = LS_BYTES / 16;
    localparam int LINE_W = $clog2(LINES);

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    typedef struct packed {
        logic [127:0] rt;
        logic [6:0]   addr;
        logic         wr;
    } stage_t;

    // Register-file bit 0 is the MSB, so the preferred word ra[0:31] is ra[127:96].
    logic [31:0] ea;
    always_comb begin
        ea = '0;
        case (addr_mode)
            2'b00:   ea = ra[127:96] + rb[127:96];
            2'b01:   ea = ra[127:96] + {{18{imm[9]}}, imm[9:0], 4'b0000};
            2'b10:   ea = {{14{imm[15]}}, imm[15:0], 2'b00};
            default: ea = '0;
        endcase
    end

    // Masking to the line index wraps modulo the store size and drops the low nibble.
    logic [LINE_W-1:0] line;
    assign line = ea[LINE_W+3:4];

    logic op_ok, accept, is_load, is_store;
    assign op_ok    = ((ls_op == OP_LOAD) || (ls_op == OP_STORE)) && (addr_mode != 2'b11);
    assign accept   = in_valid && ready && op_ok && !reset;
    assign is_load  = accept && (ls_op == OP_LOAD);
    assign is_store = accept && (ls_op == OP_STORE);

    logic              clear_we;
    logic [LINE_W-1:0] clr_cnt;

`ifdef LS_CLEAR_ON_RESET_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;
    state_t state;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // always_ff reads the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + LINE_W'(1);
            if (clr_cnt == LINE_W'(LINES - 1)) begin
                state <= S_IDLE;
                ready <= 1'b1;
            end
        end
    end

    assign clear_we = (state == S_CLEAR) && !reset;
`else
    always_ff @(posedge clk) begin
        if (reset) ready <= 1'b0;
        else       ready <= 1'b1;
    end

    assign clear_we = 1'b0;
    assign clr_cnt  = '0;
`endif

    logic              mem_we;
    logic [LINE_W-1:0] mem_waddr;
    logic [127:0]      mem_wdata;
    always_comb begin
        mem_we    = clear_we || is_store;
        mem_waddr = clear_we ? clr_cnt : line;
        mem_wdata = clear_we ? '0 : rt_st;
    end

    logic [127:0] mem [LINES];

    // NOTE: the array has no reset; committed stores must survive a pipe reset and
    // a reset loop over every line would stop it mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Stage 0 captures the read at the accept edge; a store committed one edge earlier is visible.
    stage_t pipe [LATENCY];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= is_load ? stage_t'{rt: mem[line], addr: rt_addr, wr: 1'b1} : '0;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign rt_wb        = pipe[LATENCY-1].rt;
    assign rt_addr_wb   = pipe[LATENCY-1].addr;
    assign reg_write_wb = pipe[LATENCY-1].wr;

    logic unused_bits;
    assign unused_bits = ^{ra[95:0], rb[95:0], ea[31:LINE_W+4], ea[3:0]};

endmodule

// File: tb/tb_spu_local_store_pipe.sv
// Directed bench for spu_local_store_pipe: per-edge writeback scoreboard filled from hand-computed load results.
// Covers reset, all addressing forms, wrap/alignment, bubbles, back-to-back traffic and reset with a load in flight.
module tb_spu_local_store_pipe;

    localparam int LS_BYTES = 32768;
    localparam int LATENCY  = 6;
    localparam int LINES    = LS_BYTES / 16;
    localparam int DEPTH    = 8192;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [1:0]   ls_op = 2'b00;
    logic [1:0]   addr_mode = 2'b00;
    logic [6:0]   rt_addr = '0;
    logic [127:0] ra = '0;
    logic [127:0] rb = '0;
    logic [127:0] rt_st = '0;
    logic [15:0]  imm = '0;
    logic         ready;
    logic [127:0] rt_wb;
    logic [6:0]   rt_addr_wb;
    logic         reg_write_wb;

    spu_local_store_pipe #(.LS_BYTES(LS_BYTES), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .ls_op(ls_op), .addr_mode(addr_mode),
        .rt_addr(rt_addr), .ra(ra), .rb(rb), .rt_st(rt_st), .imm(imm),
        .ready(ready), .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    // Expected writeback seen just after each numbered rising edge.
    logic         exp_we   [DEPTH];
    logic [6:0]   exp_addr [DEPTH];
    logic [127:0] exp_rt   [DEPTH];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_n, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (reset) begin
            for (int e = edge_n; e < edge_n + LATENCY + 1 && e < DEPTH; e++) begin
                exp_we[e]   = 1'b0;
                exp_addr[e] = '0;
                exp_rt[e]   = '0;
            end
        end
        #1;
        check("reg_write_wb", 128'(reg_write_wb), 128'(exp_we[edge_n]));
        check("rt_addr_wb",   128'(rt_addr_wb),   128'(exp_addr[edge_n]));
        check("rt_wb",        rt_wb,              exp_rt[edge_n]);
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] mode, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] im, input logic [127:0] st,
                         input logic [6:0] rd);
        in_valid  = 1'b1;
        ls_op     = op;
        addr_mode = mode;
        ra        = {a, {3{32'hA5A5_5A5A}}};
        rb        = {b, {3{32'h5A5A_A5A5}}};
        imm       = im;
        rt_st     = st;
        rt_addr   = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        ls_op    = 2'b00;
    endtask

    task automatic store(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] im, input logic [127:0] st);
        drive(2'b10, mode, a, b, im, st, 7'h00);
        tick();
        idle();
    endtask

    task automatic load(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] im, input logic [6:0] rd, input logic [127:0] exp);
        drive(2'b01, mode, a, b, im, 128'h0, rd);
        exp_we[edge_n + LATENCY]   = 1'b1;
        exp_addr[edge_n + LATENCY] = rd;
        exp_rt[edge_n + LATENCY]   = exp;
        tick();
        idle();
    endtask

    // Presents something that must not be accepted; no writeback is scheduled.
    task automatic bubble(input logic v, input logic [1:0] op, input logic [1:0] mode);
        drive(op, mode, 32'h0000_1000, 32'h0, 16'h0, 128'hDEAD, 7'h7F);
        in_valid = v;
        tick();
        idle();
    endtask

    task automatic wait_ready(input bit poke);
`ifdef LS_CLEAR_ON_RESET_EN
        if (poke) drive(2'b01, 2'b00, 32'h0000_1000, 32'h0, 16'h0, 128'h0, 7'h55);
        for (int i = 0; i < LINES - 1; i++) begin
            tick();
            check("ready_during_clear", 128'(ready), 128'h0);
        end
        idle();
`endif
        tick();
        check("ready_after_reset", 128'(ready), 128'h1);
    endtask

    localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D2 = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    localparam logic [127:0] D3 = 128'h13579BDF_2468ACE0_11223344_55667788;
    localparam logic [127:0] D4 = 128'hCAFEF00D_DEADBEEF_01020304_05060708;
    localparam logic [127:0] D5 = 128'h0BADC0DE_FACEB00C_99887766_55443322;
    localparam logic [127:0] D6 = 128'h77777777_66666666_55555555_44444444;

    logic [127:0] seq_data [6];

    initial begin
        for (int e = 0; e < DEPTH; e++) begin
            exp_we[e]   = 1'b0;
            exp_addr[e] = '0;
            exp_rt[e]   = '0;
        end
        seq_data[0] = 128'h10000000_00000000_00000000_000000A0;
        seq_data[1] = 128'h20000000_00000000_00000000_000000A1;
        seq_data[2] = 128'h30000000_00000000_00000000_000000A2;
        seq_data[3] = 128'h40000000_00000000_00000000_000000A3;
        seq_data[4] = 128'h50000000_00000000_00000000_000000A4;
        seq_data[5] = 128'h60000000_00000000_00000000_000000A5;

        // Reset: outputs forced to zero.
        reset = 1'b1;
        tick();
        tick();
`ifdef LS_CLEAR_ON_RESET_EN
        check("ready_in_reset", 128'(ready), 128'h0);
`endif
        reset = 1'b0;
        wait_ready(1'b1);

`ifdef LS_CLEAR_ON_RESET_EN
        // Every line reads back zero after the clear.
        for (int l = 0; l < LINES; l++) load(2'b00, 32'(l * 16), 32'h0, 16'h0, 7'(l), 128'h0);
`endif

        // x-form store 0x100+0x23 -> line 0x120; load it on the very next edge.
        store(2'b00, 32'h0000_0100, 32'h0000_0023, 16'h0, D1);
        load(2'b00, 32'h0000_0120, 32'h0, 16'h0, 7'h15, D1);
        repeat (LATENCY) tick();

        // d-form 0x200 + (-2 << 4) = 0x1E0 (imm[15:10] ignored); a-form 0x78 << 2 = 0x1E0.
        store(2'b01, 32'h0000_0200, 32'h0, 16'hFFFE, D2);
        load(2'b10, 32'hFFFF_FFFF, 32'h0, 16'h0078, 7'h22, D2);

        // Wrap and alignment: 0x8010 -> 0x0010; 0xFFFFFFF0+0x2F = 0x1F -> 0x10; d-form 0+(1<<4).
        store(2'b00, 32'h0000_8010, 32'h0, 16'h0, D3);
        load(2'b00, 32'h0000_0010, 32'h0, 16'h0, 7'h01, D3);
        load(2'b00, 32'hFFFF_FFF0, 32'h0000_002F, 16'h0, 7'h02, D3);
        load(2'b01, 32'h0, 32'h0, 16'h0001, 7'h03, D3);

        // a-form I16=-4 -> 0xFFFFFFF0 -> top line 0x7FF0.
        store(2'b10, 32'h0, 32'h0, 16'hFFFC, D4);
        load(2'b00, 32'h0000_7FF0, 32'h0, 16'h0, 7'h04, D4);
        repeat (LATENCY) tick();

        // Back-to-back stream: ordered loads with a store, ls_op=11, addr_mode=11 and in_valid=0 slots.
        for (int k = 0; k < 6; k++) store(2'b00, 32'h0000_1000 + 32'(k * 16), 32'h0, 16'h0, seq_data[k]);
        load(2'b00, 32'h0000_1000, 32'h0, 16'h0, 7'h40, seq_data[0]);
        load(2'b00, 32'h0000_1010, 32'h0, 16'h0, 7'h41, seq_data[1]);
        store(2'b00, 32'h0000_1060, 32'h0, 16'h0, D6);
        load(2'b00, 32'h0000_1020, 32'h0, 16'h0, 7'h42, seq_data[2]);
        bubble(1'b1, 2'b11, 2'b00);
        load(2'b00, 32'h0000_1030, 32'h0, 16'h0, 7'h43, seq_data[3]);
        load(2'b00, 32'h0000_1040, 32'h0, 16'h0, 7'h44, seq_data[4]);
        bubble(1'b1, 2'b01, 2'b11);
        load(2'b00, 32'h0000_1050, 32'h0, 16'h0, 7'h45, seq_data[5]);
        bubble(1'b0, 2'b01, 2'b00);
        load(2'b00, 32'h0000_1060, 32'h0, 16'h0, 7'h46, D6);
        repeat (LATENCY) tick();

        // Reset two edges after a load accept: the load never writes back.
        store(2'b00, 32'h0000_2000, 32'h0, 16'h0, D5);
        load(2'b00, 32'h0000_2000, 32'h0, 16'h0, 7'h33, D5);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        wait_ready(1'b0);
`ifdef LS_CLEAR_ON_RESET_EN
        load(2'b00, 32'h0000_2000, 32'h0, 16'h0, 7'h34, 128'h0);
`else
        load(2'b00, 32'h0000_2000, 32'h0, 16'h0, 7'h34, D5);
`endif
        repeat (LATENCY + 1) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

endmodule
